// File: rtl/wb_port_scheduler_pkg.sv
// Shared definitions for the write-back port scheduler: write-back select
// encodings and the arbitration state type.
package wb_port_scheduler_pkg;

   localparam logic [1:0] REG_WB_ALU_OUT = 2'd0;
   localparam logic [1:0] REG_WB_MEM_DAT = 2'd1;
   localparam logic [1:0] REG_WB_IMM_DAT = 2'd2;
   localparam logic [1:0] REG_WB_PC_NEXT = 2'd3;

   typedef enum logic {
      WB_ST_NORMAL = 1'b0,
      WB_ST_DRAIN  = 1'b1
   } wb_state_e;

   // Only selects that carry data from the execute stage produce a write.
   function automatic logic wb_sel_writes(input logic [1:0] sel);
      return (sel == REG_WB_ALU_OUT) || (sel == REG_WB_IMM_DAT) || (sel == REG_WB_PC_NEXT);
   endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Synchronous load-return FIFO: DEPTH entries of W bits with count/full/empty.
// Head is visible on dout the cycle after the push (no bypass).
module wb_load_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 37
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rptr_q];

   // A full FIFO refuses a push even when the head pops in the same cycle.
   always_comb begin
      push_ok = push & ~full;
      pop_ok  = pop & ~empty;
      mem_d   = mem_q;
      if (push_ok) mem_d[wptr_q] = din;
      wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop_ok  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates the single register-file write port between execute results and
// buffered load returns; execute has priority until FIFO pressure or ageing.
module wb_port_scheduler
   import wb_port_scheduler_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RADDR_W  = 5,
   parameter int LD_DEPTH = 4,
   parameter int HI_WM    = 3,
   parameter int MAX_WAIT = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               exe_valid,
   output logic               exe_ready,
   input  logic [RADDR_W-1:0] exe_rd,
   input  logic [1:0]         exe_wb_sel,
   input  logic [XLEN-1:0]    exe_alu,
   input  logic [XLEN-1:0]    exe_imm,
   input  logic [XLEN-1:0]    exe_pc_next,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [RADDR_W-1:0] ld_rd,
   input  logic [XLEN-1:0]    ld_data,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]    rf_wdata,
   output logic               ld_pending
);

   localparam int CW    = $clog2(LD_DEPTH) + 1;
   localparam int AGE_W = $clog2(MAX_WAIT + 1);
   localparam int EW    = RADDR_W + XLEN;
   localparam logic [CW-1:0]    HI_CNT  = HI_WM[CW-1:0];
   localparam logic [AGE_W-1:0] AGE_MAX = MAX_WAIT[AGE_W-1:0];

   wb_state_e          state_q, state_d;
   logic [AGE_W-1:0]   age_q, age_d;
   logic               rf_we_q, rf_we_d;
   logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count, count_next;
   logic [EW-1:0]      fifo_head;
   logic               exe_wins, ld_push, ld_pop;
   logic [XLEN-1:0]    exe_data;

   wb_load_fifo #(.DEPTH(LD_DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ld_push),
      .pop   (ld_pop),
      .din   ({ld_rd, ld_data}),
      .dout  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ld_ready   = ~fifo_full;
   assign ld_pending = ~fifo_empty;
   assign rf_we      = rf_we_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_wdata   = rf_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WB_ST_NORMAL;
         age_q      <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         age_q      <= age_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Pressure is judged on the occupancy after this cycle's push/pop.
   always_comb begin
      count_next = fifo_count + CW'(ld_push) - CW'(ld_pop);
      if (fifo_empty || ld_pop) age_d = '0;
      else if (age_q != AGE_MAX) age_d = age_q + AGE_W'(1);
      else age_d = age_q;
      state_d = state_q;
      case (state_q)
         WB_ST_NORMAL: if (count_next >= HI_CNT || age_d == AGE_MAX) state_d = WB_ST_DRAIN;
         WB_ST_DRAIN:  if (count_next == '0) state_d = WB_ST_NORMAL;
         default:      state_d = WB_ST_NORMAL;
      endcase
   end

   // An execute transfer to x0 takes no port slot, so the head may still pop.
   always_comb begin
      exe_ready = (state_q == WB_ST_NORMAL);
      exe_wins  = exe_valid & exe_ready & (exe_rd != '0);
      ld_push   = ld_valid & ~fifo_full & (ld_rd != '0);
      ld_pop    = ~fifo_empty & ~exe_wins;
      case (exe_wb_sel)
         REG_WB_ALU_OUT: exe_data = exe_alu;
         REG_WB_IMM_DAT: exe_data = exe_imm;
         REG_WB_PC_NEXT: exe_data = exe_pc_next;
         default:        exe_data = '0;
      endcase
      rf_we_d    = 1'b0;
      rf_waddr_d = '0;
      rf_wdata_d = '0;
      if (exe_wins) begin
         rf_we_d    = wb_sel_writes(exe_wb_sel);
         rf_waddr_d = rf_we_d ? exe_rd : '0;
         rf_wdata_d = rf_we_d ? exe_data : '0;
      end else if (ld_pop) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = fifo_head[EW-1:XLEN];
         rf_wdata_d = fifo_head[XLEN-1:0];
      end
   end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: directed scenarios plus random traffic checked
// against a queue-based reference of the write-port arbitration rules.
module tb_wb_port_scheduler;
   import wb_port_scheduler_pkg::*;

   localparam int LD_DEPTH = 4;
   localparam int HI_WM    = 3;
   localparam int MAX_WAIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exe_valid, ld_valid;
   logic [4:0]  exe_rd, ld_rd;
   logic [1:0]  exe_wb_sel;
   logic [31:0] exe_alu, exe_imm, exe_pc_next, ld_data;
   logic        exe_ready, ld_ready, rf_we, ld_pending;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        f_exe_ready, f_ld_ready, f_rf_we, f_ld_pending;
   logic [4:0]  f_rf_waddr;
   logic [31:0] f_rf_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   logic [36:0] mq[$];
   bit          m_drain;
   int          m_age;
   bit          m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;

   always #5 clk = ~clk;

   wb_port_scheduler u_dut (
      .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_ready(exe_ready),
      .exe_rd(exe_rd), .exe_wb_sel(exe_wb_sel), .exe_alu(exe_alu), .exe_imm(exe_imm),
      .exe_pc_next(exe_pc_next), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
      .ld_data(ld_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .ld_pending(ld_pending)
   );

   // Watermark equal to depth, so the FIFO can actually be filled.
   wb_port_scheduler #(.HI_WM(4)) u_full (
      .clk(clk), .rst_n(rst_n), .exe_valid(exe_valid), .exe_ready(f_exe_ready),
      .exe_rd(exe_rd), .exe_wb_sel(exe_wb_sel), .exe_alu(exe_alu), .exe_imm(exe_imm),
      .exe_pc_next(exe_pc_next), .ld_valid(ld_valid), .ld_ready(f_ld_ready), .ld_rd(ld_rd),
      .ld_data(ld_data), .rf_we(f_rf_we), .rf_waddr(f_rf_waddr), .rf_wdata(f_rf_wdata),
      .ld_pending(f_ld_pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_drain = 0;
      m_age   = 0;
      m_we    = 0;
   endtask

   // One cycle of the arbitration rules applied to the current inputs.
   task automatic model_step();
      int          sz;
      bit          ex_win, pop, push;
      logic [36:0] h;
      sz     = mq.size();
      ex_win = exe_valid && !m_drain && (exe_rd != 5'd0);
      pop    = (sz != 0) && !ex_win;
      push   = ld_valid && (sz < LD_DEPTH) && (ld_rd != 5'd0);
      m_we   = 0;
      if (ex_win && exe_wb_sel != REG_WB_MEM_DAT) begin
         m_we    = 1;
         m_waddr = exe_rd;
         m_wdata = (exe_wb_sel == REG_WB_ALU_OUT) ? exe_alu :
                   (exe_wb_sel == REG_WB_IMM_DAT) ? exe_imm : exe_pc_next;
      end
      if (pop) begin
         h       = mq.pop_front();
         m_we    = 1;
         m_waddr = h[36:32];
         m_wdata = h[31:0];
      end
      if (push) mq.push_back({ld_rd, ld_data});
      if (sz == 0 || pop) m_age = 0;
      else if (m_age < MAX_WAIT) m_age = m_age + 1;
      if (!m_drain) m_drain = (mq.size() >= HI_WM) || (m_age >= MAX_WAIT);
      else m_drain = (mq.size() != 0);
   endtask

   task automatic step(input logic ev, input logic [4:0] erd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pc,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
      exe_valid = ev; exe_rd = erd; exe_wb_sel = sel;
      exe_alu = alu; exe_imm = imm; exe_pc_next = pc;
      ld_valid = lv; ld_rd = lrd; ld_data = ld;
      chk("exe_ready", exe_ready, !m_drain);
      chk("ld_ready", ld_ready, mq.size() < LD_DEPTH);
      chk("ld_pending", ld_pending, mq.size() != 0);
      model_step();
      @(posedge clk);
      #1;
      chk("rf_we", rf_we, m_we);
      if (m_we) begin
         chk("rf_waddr", rf_waddr, m_waddr);
         chk("rf_wdata", rf_wdata, m_wdata);
      end
   endtask

   task automatic idle();
      step(0, 0, REG_WB_ALU_OUT, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      exe_valid = 0; ld_valid = 0;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with every input held high.
      rst_n = 1'b0;
      exe_valid = 1; exe_rd = '1; exe_wb_sel = '1; exe_alu = '1; exe_imm = '1; exe_pc_next = '1;
      ld_valid = 1; ld_rd = '1; ld_data = '1;
      model_clear();
      #12;
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_exe_ready", exe_ready, 1);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_ld_pending", ld_pending, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();

      // Execute selects and x0.
      step(1, 5, REG_WB_ALU_OUT, 32'hA5A5A5A5, 32'h1, 32'h2, 0, 0, 0);
      chk("exe_alu_we", rf_we, 1);
      chk("exe_alu_addr", rf_waddr, 5);
      chk("exe_alu_data", rf_wdata, 32'hA5A5A5A5);
      step(1, 5, REG_WB_PC_NEXT, 32'h3, 32'h4, 32'h00001000, 0, 0, 0);
      chk("exe_pc_data", rf_wdata, 32'h00001000);
      step(1, 9, REG_WB_IMM_DAT, 32'h3, 32'hDEADBEEF, 32'h5, 0, 0, 0);
      chk("exe_imm_data", rf_wdata, 32'hDEADBEEF);
      step(1, 0, REG_WB_ALU_OUT, 32'h77, 0, 0, 0, 0, 0);
      chk("exe_x0_we", rf_we, 0);
      step(1, 6, REG_WB_MEM_DAT, 32'h77, 0, 0, 0, 0, 0);
      chk("exe_mem_we", rf_we, 0);

      // Ageing: one load starved by continuous execute traffic.
      step(1, 3, REG_WB_ALU_OUT, $urandom, 0, 0, 1, 7, 32'hBBBBBBBB);
      for (int i = 0; i < 8; i++) step(1, 3, REG_WB_ALU_OUT, $urandom, 0, 0, 0, 0, 0);
      chk("age_drain_ready", exe_ready, 0);
      step(1, 3, REG_WB_ALU_OUT, $urandom, 0, 0, 0, 0, 0);
      chk("age_pop_addr", rf_waddr, 7);
      chk("age_pop_data", rf_wdata, 32'hBBBBBBBB);
      chk("age_back_normal", exe_ready, 1);

      // Watermark: three back-to-back loads.
      for (int i = 0; i < 3; i++) step(1, 4, REG_WB_ALU_OUT, $urandom, 0, 0, 1, 5'(20 + i), 32'hC0 + i);
      chk("wm_drain_ready", exe_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 4, REG_WB_ALU_OUT, $urandom, 0, 0, 0, 0, 0);
         chk("wm_pop_order", rf_waddr, 20 + i);
      end
      chk("wm_back_normal", exe_ready, 1);

      // Filling to full on the high-watermark instance.
      apply_reset();
      for (int i = 0; i < 4; i++) step(1, 1, REG_WB_ALU_OUT, 32'h11, 0, 0, 1, 5'(10 + i), 32'hD0 + i);
      chk("full_exe_we", f_rf_we, 1);
      chk("full_exe_addr", f_rf_waddr, 1);
      chk("full_ld_ready", f_ld_ready, 0);
      chk("full_exe_ready", f_exe_ready, 0);
      step(1, 1, REG_WB_ALU_OUT, 32'h11, 0, 0, 1, 14, 32'hD4);
      chk("full_pop0_addr", f_rf_waddr, 10);
      chk("full_pop0_data", f_rf_wdata, 32'hD0);
      chk("full_ready_again", f_ld_ready, 1);
      for (int i = 1; i < 4; i++) begin
         step(1, 1, REG_WB_ALU_OUT, 32'h11, 0, 0, 0, 0, 0);
         chk("full_pop_addr", f_rf_waddr, 10 + i);
         chk("full_pop_data", f_rf_wdata, 32'hD0 + i);
      end
      chk("full_normal", f_exe_ready, 1);
      chk("full_empty", f_ld_pending, 0);
      step(0, 0, REG_WB_ALU_OUT, 0, 0, 0, 0, 0, 0);
      chk("full_refused_push", f_rf_we, 0);

      // Push into an empty FIFO is not bypassed to the port.
      apply_reset();
      step(0, 0, REG_WB_ALU_OUT, 0, 0, 0, 1, 9, 32'h99);
      chk("nobypass_we", rf_we, 0);
      idle();
      chk("nobypass_next_we", rf_we, 1);
      chk("nobypass_next_addr", rf_waddr, 9);

      // Asynchronous reset while draining with two entries held.
      apply_reset();
      for (int i = 0; i < 3; i++) step(1, 2, REG_WB_ALU_OUT, $urandom, 0, 0, 1, 5'(24 + i), $urandom);
      step(0, 0, REG_WB_ALU_OUT, 0, 0, 0, 0, 0, 0);
      chk("rst6_pending", ld_pending, 1);
      chk("rst6_draining", exe_ready, 0);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      chk("rst6_we", rf_we, 0);
      chk("rst6_waddr", rf_waddr, 0);
      chk("rst6_wdata", rf_wdata, 0);
      chk("rst6_empty", ld_pending, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();
      chk("rst6_normal", exe_ready, 1);

      // Random traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         logic [4:0] erd, lrd;
         logic [1:0] sel;
         erd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         case ($urandom_range(0, 2))
            0:       sel = REG_WB_ALU_OUT;
            1:       sel = REG_WB_IMM_DAT;
            default: sel = REG_WB_PC_NEXT;
         endcase
         step($urandom_range(0, 9) < 7, erd, sel, $urandom, $urandom, $urandom,
              $urandom_range(0, 9) < 4, lrd, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
